// File: rtl/nnrv_pkg.sv
// Shared nnrv definitions: program-loader FSM states and frame constants.
package nnrv_pkg;

   localparam int DEFAULT_XLEN = 64;
   localparam int BYTES_PER_WORD = DEFAULT_XLEN / 8;
   localparam logic [7:0] LOADER_MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

endpackage

// File: rtl/nnrv_loader_asm.sv
// Byte-to-word shift assembler: little-endian packing, one-cycle word_full pulse
// in the cycle after the byte that completes a word.
module nnrv_loader_asm #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      data_byte,
   input  logic            shift,
   input  logic            clear,
   output logic [XLEN-1:0] word,
   output logic            word_full
);

   localparam int BPW = XLEN / 8;
   localparam int CW = $clog2(BPW + 1);

   logic [XLEN-1:0] word_reg;
   logic [CW-1:0]   count_reg;
   logic            full_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
      end else if (clear) begin
         word_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
      end else begin
         full_reg <= 1'b0;
         if (shift) begin
            // Bytes enter at the top so the first byte ends up in [7:0].
            word_reg <= {data_byte, word_reg[XLEN-1:8]};
            if (count_reg == CW'(BPW - 1)) begin
               count_reg <= '0;
               full_reg  <= 1'b1;
            end else begin
               count_reg <= count_reg + CW'(1);
            end
         end
      end
   end

   assign word      = word_reg;
   assign word_full = full_reg;

endmodule

// File: rtl/nnrv_loader.sv
// Program loader: packs host bytes into XLEN-bit RAM words and holds the core in
// reset until a complete image is written. Checksum trailer enabled by NNRV_LOADER_CSUM_EN.
module nnrv_loader
   import nnrv_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int ADDR_WIDTH = 8,
   parameter int MASK_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_byte_valid,
   input  logic [7:0]            i_byte_data,
   output logic                  o_byte_ready,
   output logic                  o_ram_wr_en,
   output logic [XLEN-1:0]       o_ram_wr_addr,
   output logic [MASK_WIDTH-1:0] o_ram_wr_mask,
   output logic [XLEN-1:0]       o_ram_wr_data,
   output logic                  o_core_rst,
   output logic                  o_done,
   output logic                  o_err
);

   localparam int CNT_WIDTH = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
   localparam longint DEPTH = longint'(1) << ADDR_WIDTH;

`ifdef NNRV_LOADER_CSUM_EN
   localparam loader_state_t AFTER_DATA = CSUM;
`else
   localparam loader_state_t AFTER_DATA = DONE;
`endif

   loader_state_t         state_reg, state_next;
   logic [7:0]            len_reg, len_next;
   logic [CNT_WIDTH-1:0]  wcnt_reg, wcnt_next;
   logic                  run_reg;
   logic                  done_reg;
   logic                  err_reg;
   logic                  core_rst_reg;
`ifdef NNRV_LOADER_CSUM_EN
   logic [7:0]            csum_reg, csum_next;
`endif

   logic                  accept;
   logic                  asm_shift;
   logic                  asm_clear;
   logic                  word_full;
   logic [XLEN-1:0]       asm_word;
   logic [ADDR_WIDTH-1:0] wr_index;
   logic                  len_overflow;

   nnrv_loader_asm #(
      .XLEN(XLEN)
   ) u_asm (
      .clk       (i_clk),
      .rst       (i_rst),
      .data_byte (i_byte_data),
      .shift     (asm_shift),
      .clear     (asm_clear),
      .word      (asm_word),
      .word_full (word_full)
   );

   // The write slot is the cycle word_full is high; the host must hold its byte then.
   assign o_byte_ready = run_reg && !word_full;
   assign accept       = i_byte_valid && o_byte_ready;
   assign len_overflow = (longint'(BASE_ADDR) + longint'(i_byte_data)) > DEPTH;
   assign wr_index     = ADDR_WIDTH'(BASE_ADDR) + wcnt_reg[ADDR_WIDTH-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg    <= IDLE;
         len_reg      <= '0;
         wcnt_reg     <= '0;
         run_reg      <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         core_rst_reg <= 1'b1;
`ifdef NNRV_LOADER_CSUM_EN
         csum_reg     <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         wcnt_reg     <= wcnt_next;
         run_reg      <= 1'b1;
         done_reg     <= (state_next == DONE);
         err_reg      <= (state_next == ERR);
         core_rst_reg <= (state_next != DONE);
`ifdef NNRV_LOADER_CSUM_EN
         csum_reg     <= csum_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      wcnt_next  = wcnt_reg;
      asm_shift  = 1'b0;
      asm_clear  = 1'b0;
`ifdef NNRV_LOADER_CSUM_EN
      csum_next  = csum_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (accept && (i_byte_data == LOADER_MAGIC)) state_next = LEN;
         end
         LEN: begin
            if (accept) begin
               len_next  = i_byte_data;
               wcnt_next = '0;
               asm_clear = 1'b1;
`ifdef NNRV_LOADER_CSUM_EN
               csum_next = '0;
`endif
               if (i_byte_data == 8'd0) state_next = AFTER_DATA;
               else if (len_overflow)   state_next = ERR;
               else                     state_next = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               asm_shift = 1'b1;
`ifdef NNRV_LOADER_CSUM_EN
               csum_next = csum_reg ^ i_byte_data;
`endif
            end
            // Count advances in the write slot, so the last word is in RAM before leaving DATA.
            if (word_full) begin
               wcnt_next = wcnt_reg + CNT_WIDTH'(1);
               if (wcnt_next == CNT_WIDTH'(len_reg)) state_next = AFTER_DATA;
            end
         end
`ifdef NNRV_LOADER_CSUM_EN
         CSUM: begin
            if (accept) state_next = (i_byte_data == csum_reg) ? DONE : ERR;
         end
`endif
         DONE: begin
            state_next = DONE;
         end
         ERR: begin
            if (accept && (i_byte_data == LOADER_MAGIC)) state_next = LEN;
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_ram_wr_en   = word_full;
   assign o_ram_wr_addr = word_full ? XLEN'(wr_index) : '0;
   assign o_ram_wr_data = word_full ? asm_word : '0;

   genvar gi;
   generate
      for (gi = 0; gi < MASK_WIDTH; gi++) begin : g_mask
         assign o_ram_wr_mask[gi] = word_full;
      end
   endgenerate

   assign o_core_rst = core_rst_reg;
   assign o_done     = done_reg;
   assign o_err      = err_reg;

endmodule

// File: tb/tb_nnrv_loader.sv
// Directed bench for nnrv_loader: reset, nominal frame, checksum error, length
// overflow (second instance at BASE_ADDR=250), backpressure and mid-frame reset.
module tb_nnrv_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        ready, wr_en, core_rst, done, err;
   logic [63:0] wr_addr, wr_data;
   logic [7:0]  wr_mask;

   logic        hi_valid = 1'b0;
   logic [7:0]  hi_data = 8'h00;
   logic        hi_ready, hi_wr_en, hi_core_rst, hi_done, hi_err;
   logic [63:0] hi_wr_addr, hi_wr_data;
   logic [7:0]  hi_wr_mask;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int last_acc = 0;
   logic [63:0] wr_addr_log[$];
   logic [63:0] wr_data_log[$];
   int          wr_cyc_log[$];
   int   done_cyc = -1;
   logic prev_done = 1'b0;
   int   ready_bad = 0;
   int   mask_bad = 0;
   int   stall_cnt = 0;
   int   hi_wr_cnt = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   nnrv_loader #(.XLEN(64), .ADDR_WIDTH(8), .MASK_WIDTH(8), .BASE_ADDR(0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(valid), .i_byte_data(data),
      .o_byte_ready(ready), .o_ram_wr_en(wr_en), .o_ram_wr_addr(wr_addr),
      .o_ram_wr_mask(wr_mask), .o_ram_wr_data(wr_data), .o_core_rst(core_rst),
      .o_done(done), .o_err(err)
   );

   nnrv_loader #(.XLEN(64), .ADDR_WIDTH(8), .MASK_WIDTH(8), .BASE_ADDR(250)) u_hi (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(hi_valid), .i_byte_data(hi_data),
      .o_byte_ready(hi_ready), .o_ram_wr_en(hi_wr_en), .o_ram_wr_addr(hi_wr_addr),
      .o_ram_wr_mask(hi_wr_mask), .o_ram_wr_data(hi_wr_data), .o_core_rst(hi_core_rst),
      .o_done(hi_done), .o_err(hi_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) begin
         wr_addr_log.push_back(wr_addr);
         wr_data_log.push_back(wr_data);
         wr_cyc_log.push_back(cyc);
         $display("RAM write: cycle %0d addr %0d data %h", cyc, wr_addr, wr_data);
      end
      if ((wr_en && wr_mask !== 8'hFF) || (!wr_en && wr_mask !== 8'h00)) mask_bad <= mask_bad + 1;
      if (mon_en && (ready !== !wr_en)) ready_bad <= ready_bad + 1;
      if (mon_en && valid && !ready) stall_cnt <= stall_cnt + 1;
      if (done && !prev_done) done_cyc <= cyc;
      prev_done <= done;
      if (hi_wr_en) hi_wr_cnt <= hi_wr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_ready"},    64'(ready),    64'd0);
      chk({pfx, "_wr_en"},    64'(wr_en),    64'd0);
      chk({pfx, "_wr_addr"},  wr_addr,       64'd0);
      chk({pfx, "_wr_mask"},  64'(wr_mask),  64'd0);
      chk({pfx, "_wr_data"},  wr_data,       64'd0);
      chk({pfx, "_core_rst"}, 64'(core_rst), 64'd1);
      chk({pfx, "_done"},     64'(done),     64'd0);
      chk({pfx, "_err"},      64'(err),      64'd0);
   endtask

   // Presents a byte and holds it until accepted (bounded); valid stays high afterwards.
   task automatic send(input logic [7:0] b);
      int w;
      w = 0;
      valid = 1'b1;
      data = b;
      while (!ready && w < 20) begin
         tick();
         w++;
      end
      if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
      tick();
      last_acc = cyc;
   endtask

   task automatic send_hi(input logic [7:0] b);
      hi_valid = 1'b1;
      hi_data = b;
      chk("hi_ready", 64'(hi_ready), 64'd1);
      tick();
      hi_valid = 1'b0;
   endtask

   task automatic idle();
      valid = 1'b0;
      data = 8'h00;
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while (!done && w < 10) begin
         tick();
         w++;
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      mon_en = 1'b1;
   endtask

   initial begin
      int n0, s0, data_acc;

      // Reset values, then ready in the first cycle after deassertion
      tick();
      tick();
      chk_reset_vals("rst");
      rst = 1'b0;
      tick();
      chk("ready_first_cycle", 64'(ready), 64'd1);
      chk("hi_ready_first_cycle", 64'(hi_ready), 64'd1);
      mon_en = 1'b1;

      // Nominal two-word frame with valid held high throughout
      n0 = wr_addr_log.size();
      s0 = stall_cnt;
      send(8'hA5);
      send(8'h02);
      for (int i = 1; i <= 16; i++) send(8'(i));
      data_acc = last_acc;
`ifdef NNRV_LOADER_CSUM_EN
      send(8'h10);
`endif
      wait_done();
      idle();
      tick();
      chk("nom_wr_count", 64'(wr_addr_log.size() - n0), 64'd2);
      chk("nom_addr0", wr_addr_log[n0], 64'd0);
      chk("nom_data0", wr_data_log[n0], 64'h0807060504030201);
      chk("nom_addr1", wr_addr_log[n0 + 1], 64'd1);
      chk("nom_data1", wr_data_log[n0 + 1], 64'h100F0E0D0C0B0A09);
      chk("nom_wr_latency", 64'(wr_cyc_log[n0 + 1]), 64'(data_acc));
`ifdef NNRV_LOADER_CSUM_EN
      chk("nom_done_latency", 64'(done_cyc), 64'(last_acc));
`else
      chk("nom_done_latency", 64'(done_cyc), 64'(data_acc + 1));
`endif
      chk("nom_done", 64'(done), 64'd1);
      chk("nom_core_rst", 64'(core_rst), 64'd0);
      chk("nom_err", 64'(err), 64'd0);
      chk("nom_stall_cycles", 64'(stall_cnt - s0), 64'd2);

      // Bytes in DONE are accepted and ignored
      n0 = wr_addr_log.size();
      send(8'hA5);
      send(8'h01);
      send(8'hFF);
      idle();
      tick();
      chk("done_ignore_wr", 64'(wr_addr_log.size() - n0), 64'd0);
      chk("done_sticky", 64'(done), 64'd1);
      chk("done_core_rst", 64'(core_rst), 64'd0);

      // One all-ones word; bad checksum where the trailer exists
      do_reset();
      chk("ready_after_reset2", 64'(ready), 64'd1);
      n0 = wr_addr_log.size();
      send(8'hA5);
      send(8'h01);
      for (int i = 0; i < 8; i++) send(8'hFF);
`ifdef NNRV_LOADER_CSUM_EN
      send(8'h01);
      idle();
      tick();
      chk("bad_wr_count", 64'(wr_addr_log.size() - n0), 64'd1);
      chk("bad_wr_data", wr_data_log[n0], 64'hFFFFFFFFFFFFFFFF);
      chk("bad_err", 64'(err), 64'd1);
      chk("bad_core_rst", 64'(core_rst), 64'd1);
      chk("bad_done", 64'(done), 64'd0);
      send(8'hA5);
      chk("err_cleared", 64'(err), 64'd0);
      send(8'h00);
      send(8'h00);
      idle();
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_core_rst", 64'(core_rst), 64'd0);
`else
      wait_done();
      idle();
      tick();
      chk("ones_wr_count", 64'(wr_addr_log.size() - n0), 64'd1);
      chk("ones_wr_data", wr_data_log[n0], 64'hFFFFFFFFFFFFFFFF);
      chk("ones_done", 64'(done), 64'd1);
      chk("ones_err", 64'(err), 64'd0);
`endif

      // Length overflow at BASE_ADDR=250: 250+7 overflows, 250+6 fits exactly
      send_hi(8'hA5);
      send_hi(8'h07);
      chk("ovf_err", 64'(hi_err), 64'd1);
      chk("ovf_core_rst", 64'(hi_core_rst), 64'd1);
      chk("ovf_done", 64'(hi_done), 64'd0);
      send_hi(8'hA5);
      chk("ovf_err_clear", 64'(hi_err), 64'd0);
      send_hi(8'h06);
      chk("edge_len_ok", 64'(hi_err), 64'd0);
      tick();
      tick();
      chk("ovf_no_writes", 64'(hi_wr_cnt), 64'd0);

      // Asynchronous reset after three data bytes, then a clean frame
      do_reset();
      send(8'hA5);
      send(8'h02);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      idle();
      tick();
      tick();
      rst = 1'b0;
      tick();
      mon_en = 1'b1;
      chk("ready_after_midrst", 64'(ready), 64'd1);
      n0 = wr_addr_log.size();
      send(8'hA5);
      send(8'h01);
      for (int i = 1; i <= 8; i++) send(8'(16 + i));
`ifdef NNRV_LOADER_CSUM_EN
      send(8'h08);
`endif
      wait_done();
      idle();
      tick();
      chk("clean_wr_count", 64'(wr_addr_log.size() - n0), 64'd1);
      chk("clean_addr", wr_addr_log[n0], 64'd0);
      chk("clean_data", wr_data_log[n0], 64'h1817161514131211);
      chk("clean_done", 64'(done), 64'd1);
      chk("clean_err", 64'(err), 64'd0);

      chk("ready_vs_write_slot", 64'(ready_bad), 64'd0);
      chk("mask_rule", 64'(mask_bad), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
